serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder sequencer that sits directly upstream of the one-bit combinational full-adder cell (inputs A, B, C; outputs S, CO).
- Accepts two WIDTH-bit operands and a carry-in, drives them into the cell one bit per clock starting at the LSB, and registers the cell's carry between cycles.
- Collects the sum bits and presents the WIDTH-bit result plus carry-out with a start/busy/done handshake.
- Gives the team a multi-bit adder built from one full-adder instance.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on the accepted start edge.
- b_in  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; high while in DONE.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out register.
- fa_a  output  1  to full-adder A.
- fa_b  output  1  to full-adder B.
- fa_c  output  1  to full-adder C (carry-in).
- fa_s  input  1  from full-adder S; combinational, same cycle.
- fa_co  input  1  from full-adder CO; combinational, same cycle.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - a_sh, b_sh, s_sh, carry and bit counter clear to 0.
  - sum=0, cout=0, busy=0, done=0, fa_a=fa_b=fa_c=0.
- Reset asserted mid-operation aborts the addition. No done pulse is issued. sum/cout read 0 after reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - fa_a/fa_b/fa_c forced to 0.
  - If start=1 at edge k: load a_sh=a_in, b_sh=b_in, carry=cin, cnt=0, then go to RUN.
  - start=0: remain in IDLE.
- RUN:
  - Combinational drive: fa_a=a_sh[0], fa_b=b_sh[0], fa_c=carry.
  - Each edge:
    - s_sh shifts right with fa_s entering at the MSB.
    - a_sh and b_sh shift right.
    - carry<=fa_co.
    - cnt increments.
  - On the edge where cnt==WIDTH-1:
    - Go to DONE.
    - Load sum with the final shifted value, i.e. {fa_s, s_sh[WIDTH-1:1]}.
    - Load cout<=fa_co.
- DONE:
  - Lasts exactly one cycle; done=1; fa_* forced to 0.
  - Next edge returns to IDLE unconditionally.
- Latency: start accepted at edge k, so bits are processed at edges k+1..k+WIDTH and done is high in the cycle following edge k+WIDTH. sum/cout are valid in that cycle.
- Throughput: one addition per WIDTH+2 cycles. A new start may be asserted in the cycle after DONE.
- start while busy=1 (RUN or DONE) is ignored. It is not queued, and operands in flight are unaffected.
- a_in/b_in/cin may change freely after the accepted start edge.
- sum/cout hold their last completed value until the next completion or reset. They do not change during RUN.
- Arithmetic: {cout,sum} = a_in + b_in + cin, modulo 2^(WIDTH+1), unsigned.
- cnt width: ceil(log2(WIDTH)) bits. It never wraps within an operation.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on the accepted start edge.
  - sub=1: b_sh loads ~b_in and carry loads 1, ignoring cin, giving sum=a_in-b_in. cout=1 means no borrow.
  - sub=0: addition exactly as above.
- Undefined:
  - No sub port. Addition only; logic is identical to the sub=0 path.

Test Plan (WIDTH=8):
- Basic add: rst pulse; start with a_in=0x5A, b_in=0x33, cin=0 -> done high exactly 9 cycles after the start edge; sum=0x8D, cout=0; busy high for 9 cycles.
- Full carry ripple: a_in=0xFF, b_in=0x01, cin=0 -> sum=0x00, cout=1. Repeat with a_in=0xFF, b_in=0x00, cin=1 -> sum=0x00, cout=1.
- Bit-level drive: a_in=0x01, b_in=0x01, cin=0 -> during RUN, cycle 1 shows fa_a=1, fa_b=1, fa_c=0; cycle 2 shows fa_c=1. Final sum=0x02, cout=0.
- Start ignored while busy: start 0x10+0x20; re-pulse start with 0xFF+0xFF at RUN cycle 3 and again during DONE -> single done pulse, sum=0x30; a subsequent idle start works normally.
- Reset mid-operation: start 0xAA+0x55, assert rst at RUN cycle 4 -> outputs 0 immediately, no done pulse; after release, start 0x01+0x02 -> sum=0x03.
- With SERIAL_ADDER_SUB_EN defined: sub=1, a_in=0x10, b_in=0x01 -> sum=0x0F, cout=1; sub=1, a_in=0x00, b_in=0x01 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial adder sequencer placed directly upstream of a single one-bit
// combinational full-adder cell. It accepts two WIDTH-bit operands and a
// carry-in, feeds them to the cell one bit per clock starting at the LSB,
// and registers the cell's carry between cycles. The sum bits are collected
// and presented as a WIDTH-bit result plus carry-out, with a start/busy/done
// handshake.
//
// Optional build macro: SERIAL_ADDER_SUB_EN
//   When this macro is defined, the module gains a `sub` input. With sub=1
//   the module computes a_in - b_in: it loads ~b_in and forces the carry-in
//   to 1. In that case cout=1 means no borrow occurred.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   begin an addition; sampled only while idle
//   a_in   in   operand A, captured on the accepted start edge
//   b_in   in   operand B, captured on the accepted start edge
//   cin    in   carry-in, captured on the accepted start edge
//   sub    in   (SERIAL_ADDER_SUB_EN only) subtract request, captured on start
//   busy   out  high while an operation is running or completing
//   done   out  one-cycle completion pulse
//   sum    out  result register, holds the last completed value
//   cout   out  carry-out register, holds the last completed value
//   fa_a   out  full-adder A input
//   fa_b   out  full-adder B input
//   fa_c   out  full-adder carry input
//   fa_s   in   full-adder sum (combinational, same cycle)
//   fa_co  in   full-adder carry-out (combinational, same cycle)
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  // Only WIDTH-1 collected bits need storage; the current fa_s completes
  // the word on the final edge.
  logic [WIDTH-2:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  assign s_next   = {fa_s, s_sh};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtraction: a + ~b + 1
  assign b_load = sub ? ~b_in : b_in;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b_in;
  assign c_load = cin;
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_c      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        fa_a = a_sh[0];
        fa_b = b_sh[0];
        fa_c = carry;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        // Operand capture
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
          end
        end
        // One bit through the full-adder cell per clock
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_next[WIDTH-1:1];
          carry <= fa_co;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= s_next;
            cout <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in, b_in;
  logic             cin;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             fa_a, fa_b, fa_c;
  logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif

  always #5 clk = ~clk;

  // The external one-bit full-adder cell
  assign fa_s  = fa_a ^ fa_b ^ fa_c;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .fa_a  (fa_a),
    .fa_b  (fa_b),
    .fa_c  (fa_c),
    .fa_s  (fa_s),
    .fa_co (fa_co)
  );

  typedef struct packed {
    logic             cout;
    logic [WIDTH-1:0] sum;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain op; 1: check cell drive; 2: re-pulse start while busy;
  // 3: reset in RUN cycle 4. Called and returns on a negedge.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic s, input int mode);
    exp_t e;
    int   busy_cnt;
    bit   seen;
    logic [WIDTH:0] r;
    a_in  = a;
    b_in  = b;
    cin   = c;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = s;
`endif
    if (s) r = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    else   r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    e.cout = r[WIDTH];
    e.sum  = r[WIDTH-1:0];
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = WIDTH'($urandom);
    b_in  = WIDTH'($urandom);
    cin   = 1'($urandom);
    busy_cnt = 0;
    seen     = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (mode == 1 && n == 1) begin
        chk("drive_c1_fa_a", fa_a, 1);
        chk("drive_c1_fa_b", fa_b, 1);
        chk("drive_c1_fa_c", fa_c, 0);
      end
      if (mode == 1 && n == 2) chk("drive_c2_fa_c", fa_c, 1);
      if (mode == 2 && n == 3) begin
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'hFF;
      end
      if (mode == 2 && n == 4) start = 1'b0;
      if (mode == 3 && n == 4) begin
        rst = 1'b1;
        #1;
        chk("rst_mid_sum", sum, 0);
        chk("rst_mid_cout", cout, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_fa", {fa_a, fa_b, fa_c}, 0);
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        for (int m = 0; m < 12; m++) begin
          @(negedge clk);
          chk("rst_mid_no_done", done, 0);
          chk("rst_mid_no_busy", busy, 0);
        end
        return;
      end
      if (done) begin
        seen = 1'b1;
        chk("latency", n, WIDTH + 1);
        chk("busy_cycles", busy_cnt, WIDTH + 1);
        if (sb.size() == 0) begin
          chk("sb_nonempty", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("sum", sum, e.sum);
          chk("cout", cout, e.cout);
        end
      end
    end
    chk("done_seen", seen, 1);
    if (mode == 2) begin
      start = 1'b1;
      a_in  = 8'hFF;
      b_in  = 8'hFF;
      @(negedge clk);
      chk("ignore_done_low", done, 0);
      chk("ignore_busy_low", busy, 0);
      start = 1'b0;
      for (int m = 0; m < 10; m++) begin
        @(negedge clk);
        chk("ignore_single_done", done, 0);
      end
      chk("ignore_sum_held", sum, 8'h30);
    end else begin
      @(negedge clk);
      chk("done_pulse_end", done, 0);
      chk("busy_end", busy, 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_fa", {fa_a, fa_b, fa_c}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_fa", {fa_a, fa_b, fa_c}, 0);

    do_op(8'h5A, 8'h33, 1'b0, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'hFF, 8'h00, 1'b1, 1'b0, 0);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 1);
    do_op(8'h10, 8'h20, 1'b0, 1'b0, 2);
    do_op(8'h05, 8'h07, 1'b1, 1'b0, 0);
    do_op(8'hAA, 8'h55, 1'b0, 1'b0, 3);
    do_op(8'h01, 8'h02, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 0);
`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h10, 8'h01, 1'b0, 1'b1, 0);
    do_op(8'h00, 8'h01, 1'b1, 1'b1, 0);
    do_op(8'h80, 8'h7F, 1'b1, 1'b0, 0);
`endif
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
